// File: rtl/mem_tg_csr_seq.sv
// Traffic-generator CSR sequencer: writes TG_CTRL, polls TG_STAT, reads clock counts.
// Ports: start/tg_mask request; busy/done/status/clock_count results; AVMM master.
module mem_tg_csr_seq #(
    parameter int unsigned NUM_TG      = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned CTRL_ADDR   = 'h30,
    parameter int unsigned STAT_ADDR   = 'h38,
    parameter int unsigned CLOCKS_ADDR = 'h40,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned MAX_POLLS   = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_TG-1:0]      tg_mask,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_TG-1:0]      tg_pass,
    output logic [NUM_TG-1:0]      tg_fail,
    output logic [NUM_TG-1:0]      tg_timeout,
    output logic                   seq_timeout,
    output logic [NUM_TG-1:0][63:0] clock_count,
    output logic [ADDR_W-1:0]      avmm_address,
    output logic                   avmm_read,
    output logic                   avmm_write,
    output logic [63:0]            avmm_writedata,
    output logic [7:0]             avmm_byteenable,
    input  logic                   avmm_waitrequest,
    input  logic [63:0]            avmm_readdata,
    input  logic                   avmm_readdatavalid,
    input  logic                   avmm_writeresponsevalid
);

    localparam int unsigned PW = $clog2(MAX_POLLS + 1);
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam int unsigned IW = (NUM_TG > 1) ? $clog2(NUM_TG) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_CTRL, WAIT_WRSP, RD_STAT, WAIT_STAT,
        GAP, RD_CLK, WAIT_CLK, DONE
    } state_t;

    state_t            state;
    logic [NUM_TG-1:0] mask_q;
    logic [NUM_TG-1:0] rem_q;
    logic [PW-1:0]     poll_cnt;
    logic [GW-1:0]     gap_cnt;

    logic [NUM_TG-1:0] st_act, st_pass, st_fail, st_to;
    logic              complete;
    logic [IW-1:0]     cur_idx, nxt_idx;
    logic [NUM_TG-1:0] rem_nxt;

    function automatic logic [IW-1:0] lowest(input logic [NUM_TG-1:0] m);
        lowest = '0;
        for (int i = NUM_TG - 1; i >= 0; i--)
            if (m[i]) lowest = IW'(i);
    endfunction

    function automatic logic [ADDR_W-1:0] clk_addr(input logic [IW-1:0] i);
        clk_addr = ADDR_W'(CLOCKS_ADDR) + ADDR_W'({i, 3'b000});
    endfunction

    assign avmm_byteenable = 8'hff;

    always_comb begin
        st_act  = '0;
        st_pass = '0;
        st_fail = '0;
        st_to   = '0;
        for (int n = 0; n < NUM_TG; n++) begin
            st_act[n]  = avmm_readdata[4*n];
            st_pass[n] = avmm_readdata[4*n+1];
            st_fail[n] = avmm_readdata[4*n+2];
            st_to[n]   = avmm_readdata[4*n+3];
        end
    end

    // A masked TG is finished once idle with some verdict bit set.
    assign complete = &(~mask_q | (~st_act & (st_pass | st_fail | st_to)));

    // rem_q holds the masked TGs whose clock count is still to be read.
    assign cur_idx = lowest(rem_q);
    assign rem_nxt = rem_q & ~(NUM_TG'(1) << cur_idx);
    assign nxt_idx = lowest(rem_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mask_q         <= '0;
            rem_q          <= '0;
            poll_cnt       <= '0;
            gap_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tg_pass        <= '0;
            tg_fail        <= '0;
            tg_timeout     <= '0;
            seq_timeout    <= 1'b0;
            clock_count    <= '0;
            avmm_address   <= '0;
            avmm_read      <= 1'b0;
            avmm_write     <= 1'b0;
            avmm_writedata <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    tg_pass     <= '0;
                    tg_fail     <= '0;
                    tg_timeout  <= '0;
                    seq_timeout <= 1'b0;
                    clock_count <= '0;
                    poll_cnt    <= '0;
                    mask_q      <= tg_mask;
                    rem_q       <= tg_mask;
                    if (tg_mask != '0) begin
                        busy           <= 1'b1;
                        avmm_write     <= 1'b1;
                        avmm_address   <= ADDR_W'(CTRL_ADDR);
                        avmm_writedata <= 64'(tg_mask);
                        state          <= WR_CTRL;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WR_CTRL: if (!avmm_waitrequest) begin
                    avmm_write <= 1'b0;
                    state      <= WAIT_WRSP;
                end
                WAIT_WRSP: if (avmm_writeresponsevalid) begin
                    avmm_read    <= 1'b1;
                    avmm_address <= ADDR_W'(STAT_ADDR);
                    state        <= RD_STAT;
                end
                RD_STAT: if (!avmm_waitrequest) begin
                    avmm_read <= 1'b0;
                    if (poll_cnt != PW'(MAX_POLLS))
                        poll_cnt <= poll_cnt + 1'b1;
                    state <= WAIT_STAT;
                end
                WAIT_STAT: if (avmm_readdatavalid) begin
                    if (complete) begin
                        tg_pass      <= st_pass & mask_q;
                        tg_fail      <= st_fail & mask_q;
                        tg_timeout   <= st_to & mask_q;
                        avmm_read    <= 1'b1;
                        avmm_address <= clk_addr(cur_idx);
                        state        <= RD_CLK;
                    end else if (poll_cnt == PW'(MAX_POLLS)) begin
                        tg_pass     <= st_pass & mask_q;
                        tg_fail     <= st_fail & mask_q;
                        tg_timeout  <= st_to & mask_q;
                        seq_timeout <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        gap_cnt <= GW'(POLL_GAP - 1);
                        state   <= GAP;
                    end
                end
                GAP: if (gap_cnt == '0) begin
                    avmm_read    <= 1'b1;
                    avmm_address <= ADDR_W'(STAT_ADDR);
                    state        <= RD_STAT;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                RD_CLK: if (!avmm_waitrequest) begin
                    avmm_read <= 1'b0;
                    state     <= WAIT_CLK;
                end
                WAIT_CLK: if (avmm_readdatavalid) begin
                    clock_count[cur_idx] <= avmm_readdata;
                    rem_q                <= rem_nxt;
                    if (rem_nxt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        avmm_read    <= 1'b1;
                        avmm_address <= clk_addr(nxt_idx);
                        state        <= RD_CLK;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_tg_csr_seq.sv
// Bench for mem_tg_csr_seq: table-driven sequences against a reactive AVMM sink,
// plus directed stall, empty-mask, busy-start and mid-sequence reset cases.
module tb_mem_tg_csr_seq;

    localparam int NT = 4;
    localparam int PG = 3;
    localparam int MP = 4;
    localparam logic [63:0] CLKV [4] = '{64'h100, 64'h150, 64'h200, 64'h250};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [NT-1:0]        tg_mask;
    logic                 busy, done;
    logic [NT-1:0]        tg_pass, tg_fail, tg_timeout;
    logic                 seq_timeout;
    logic [NT-1:0][63:0]  clock_count;
    logic [15:0]          avmm_address;
    logic                 avmm_read, avmm_write;
    logic [63:0]          avmm_writedata;
    logic [7:0]           avmm_byteenable;
    logic                 waitreq = 1'b0;
    logic [63:0]          rdata = '0;
    logic                 rdv = 1'b0;
    logic                 wrv = 1'b0;

    always #5 clk = ~clk;

    mem_tg_csr_seq #(
        .NUM_TG(NT), .ADDR_W(16), .CTRL_ADDR('h30), .STAT_ADDR('h38),
        .CLOCKS_ADDR('h40), .POLL_GAP(PG), .MAX_POLLS(MP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tg_mask(tg_mask),
        .busy(busy), .done(done), .tg_pass(tg_pass), .tg_fail(tg_fail),
        .tg_timeout(tg_timeout), .seq_timeout(seq_timeout),
        .clock_count(clock_count), .avmm_address(avmm_address),
        .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_waitrequest(waitreq), .avmm_readdata(rdata),
        .avmm_readdatavalid(rdv), .avmm_writeresponsevalid(wrv)
    );

    // sink configuration, written by the test only
    int          done_on_cfg = 0;
    logic [63:0] stat_final_cfg = '0;
    logic [63:0] stat_busy_cfg = '0;
    int          stall_cfg = 0;
    int          rsp_delay_cfg = 0;
    int          test_id = 0;

    // sink state and logs, written by the sink only
    int          seen_id = 0;
    int          cyc = 0;
    int          ctrl_writes, stat_reads, wr_high, unstable, bad;
    logic [63:0] ctrl_data;
    int          clk_q[$];
    int          stat_t[$];
    int          stall_left = 0;
    bit          in_cmd = 1'b0;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_data;
    int          pend_cnt = 0;
    bit          pend_wr = 1'b0;
    logic [63:0] pend_data = '0;

    always @(negedge clk) begin
        if (test_id != seen_id) begin
            seen_id     = test_id;
            ctrl_writes = 0;
            stat_reads  = 0;
            wr_high     = 0;
            unstable    = 0;
            bad         = 0;
            ctrl_data   = '0;
            clk_q.delete();
            stat_t.delete();
        end
        cyc++;
        rdv = 1'b0;
        wrv = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                if (pend_wr) wrv = 1'b1;
                else begin
                    rdv   = 1'b1;
                    rdata = pend_data;
                end
            end
        end
        if (avmm_write) wr_high++;
        if (avmm_read || avmm_write) begin
            if (!in_cmd) begin
                in_cmd     = 1'b1;
                stall_left = avmm_write ? stall_cfg : 0;
                cmd_addr   = avmm_address;
                cmd_data   = avmm_writedata;
            end else if (avmm_address !== cmd_addr || avmm_writedata !== cmd_data) begin
                unstable++;
            end
            if (stall_left > 0) begin
                waitreq = 1'b1;
                stall_left--;
            end else begin
                waitreq  = 1'b0;
                in_cmd   = 1'b0;
                pend_cnt = rsp_delay_cfg + 1;
                pend_wr  = avmm_write;
                if (avmm_write) begin
                    ctrl_writes++;
                    ctrl_data = avmm_writedata;
                    if (avmm_address != 16'h30) bad++;
                end else if (avmm_address == 16'h38) begin
                    stat_reads++;
                    stat_t.push_back(cyc);
                    pend_data = (done_on_cfg != 0 && stat_reads >= done_on_cfg)
                                ? stat_final_cfg : stat_busy_cfg;
                end else if (avmm_address >= 16'h40 && avmm_address < 16'h60
                             && avmm_address[2:0] == 3'b000) begin
                    clk_q.push_back(int'(avmm_address));
                    pend_data = CLKV[int'((avmm_address - 16'h40) >> 3)];
                end else begin
                    bad++;
                end
            end
        end else begin
            waitreq = 1'b0;
            in_cmd  = 1'b0;
        end
    end

    typedef struct {
        logic [NT-1:0] mask;
        int            done_on;
        logic [63:0]   fin;
        logic [63:0]   bsy;
        logic [NT-1:0] e_pass;
        logic [NT-1:0] e_fail;
        logic [NT-1:0] e_to;
        logic          e_seqto;
        int            e_stat;
        int            e_clk;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
        chk("busy_at_done", busy, 1'b0);
        tick();
        chk("done_width", done, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int j;
        done_on_cfg    = v.done_on;
        stat_final_cfg = v.fin;
        stat_busy_cfg  = v.bsy;
        test_id++;
        tick();
        tick();
        start   = 1'b1;
        tg_mask = v.mask;
        tick();
        start   = 1'b0;
        tg_mask = '0;
        chk("busy_on_start", busy, 1'b1);
        wait_done();
        chk("tg_pass", tg_pass, v.e_pass);
        chk("tg_fail", tg_fail, v.e_fail);
        chk("tg_timeout", tg_timeout, v.e_to);
        chk("seq_timeout", seq_timeout, v.e_seqto);
        for (int n = 0; n < NT; n++)
            chk($sformatf("clock_count%0d", n), clock_count[n],
                (v.mask[n] && !v.e_seqto) ? CLKV[n] : 64'h0);
        chk("ctrl_writes", ctrl_writes, 1);
        chk("ctrl_data", ctrl_data, 64'(v.mask));
        chk("stat_reads", stat_reads, v.e_stat);
        chk("clk_reads", clk_q.size(), v.e_clk);
        j = 0;
        for (int n = 0; n < NT; n++) begin
            if (v.mask[n] && !v.e_seqto) begin
                if (j < clk_q.size())
                    chk("clk_addr", clk_q[j], 'h40 + 8 * n);
                j++;
            end
        end
        // one WAIT_STAT cycle, POLL_GAP idle cycles, one RD_STAT cycle
        for (int i = 1; i < stat_t.size(); i++)
            chk("poll_spacing", stat_t[i] - stat_t[i-1], PG + 2);
        chk("bad_access", bad, 0);
        chk("cmd_stable", unstable, 0);
        chk("write_high_cycles", wr_high, stall_cfg + 1);
        chk("byteenable", avmm_byteenable, 8'hff);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        vecs[0] = '{4'b0101, 3, 64'h0202, 64'h1111, 4'b0101, 4'b0000, 4'b0000, 1'b0, 3, 2};
        vecs[1] = '{4'b0011, 1, 64'h0042, 64'h1111, 4'b0001, 4'b0010, 4'b0000, 1'b0, 1, 2};
        vecs[2] = '{4'b1000, 2, 64'h8002, 64'h1111, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2, 1};
        vecs[3] = '{4'b1111, 0, 64'h0000, 64'h1113, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4, 0};
        vecs[4] = '{4'b0110, 4, 64'h0480, 64'h1111, 4'b0000, 4'b0100, 4'b0010, 1'b0, 4, 2};
        vecs[5] = '{4'b0011, 0, 64'h0000, 64'h0032, 4'b0011, 4'b0000, 4'b0000, 1'b1, 4, 0};

        rst_n   = 1'b0;
        start   = 1'b0;
        tg_mask = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read", avmm_read, 1'b0);
        chk("rst_write", avmm_write, 1'b0);
        chk("rst_addr", avmm_address, 16'h0);
        chk("rst_wdata", avmm_writedata, 64'h0);
        chk("rst_seqto", seq_timeout, 1'b0);
        chk("rst_status", {tg_pass, tg_fail, tg_timeout}, 64'h0);
        chk("rst_clkcnt", |clock_count, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++)
            run_vec(vecs[k]);

        // CTRL write held off by waitrequest for five cycles
        stall_cfg = 5;
        run_vec(vecs[0]);
        stall_cfg = 0;

        // empty mask: done on the next cycle, no bus traffic, results cleared
        test_id++;
        tick();
        tick();
        start   = 1'b1;
        tg_mask = '0;
        tick();
        start   = 1'b0;
        chk("m0_done", done, 1'b1);
        chk("m0_busy", busy, 1'b0);
        tick();
        chk("m0_done_width", done, 1'b0);
        tick();
        tick();
        chk("m0_traffic", ctrl_writes + stat_reads + clk_q.size() + wr_high, 0);
        chk("m0_status", {tg_pass, tg_fail, tg_timeout, 3'b0, seq_timeout}, 64'h0);
        chk("m0_clkcnt", |clock_count, 1'b0);

        // start while busy, then reset while the status read is outstanding
        rsp_delay_cfg  = 6;
        done_on_cfg    = 1;
        stat_final_cfg = 64'h2;
        stat_busy_cfg  = 64'h1111;
        test_id++;
        tick();
        tick();
        start   = 1'b1;
        tg_mask = 4'b0001;
        tick();
        start   = 1'b0;
        n = 0;
        while (ctrl_writes == 0 && n < 100) begin
            tick();
            n++;
        end
        start   = 1'b1;
        tg_mask = 4'b1111;
        tick();
        start   = 1'b0;
        tg_mask = '0;
        n = 0;
        while (stat_reads == 0 && n < 200) begin
            tick();
            n++;
        end
        chk("rr_stat_seen", stat_reads, 1);
        chk("rr_busy_mid", busy, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rr_async_busy", busy, 1'b0);
        chk("rr_async_read", avmm_read, 1'b0);
        chk("rr_async_addr", avmm_address, 16'h0);
        chk("rr_async_wdata", avmm_writedata, 64'h0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy || avmm_read || avmm_write) seen++;
        end
        chk("rr_stale_ignored", seen, 0);
        chk("rr_ctrl_writes", ctrl_writes, 1);
        chk("rr_ctrl_data", ctrl_data, 64'h1);
        chk("rr_stat_reads", stat_reads, 1);
        chk("rr_status", {tg_pass, tg_fail, tg_timeout, 3'b0, seq_timeout}, 64'h0);
        chk("rr_clkcnt", |clock_count, 1'b0);
        rsp_delay_cfg = 0;
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_tg_csr_seq.md
MEM_TG_CSR_SEQ -- requirements
Module: mem_tg_csr_seq

Interface
REQ-001 SHALL have parameter NUM_TG, default 4, number of traffic generators controlled (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16, AVMM byte-address width.
REQ-003 SHALL have parameter CTRL_ADDR, default 'h30, byte address of TG_CTRL.
REQ-004 SHALL have parameter STAT_ADDR, default 'h38, byte address of TG_STAT.
REQ-005 SHALL have parameter CLOCKS_ADDR, default 'h40, byte address of TG0 clock count; TG n is at CLOCKS_ADDR+8n.
REQ-006 SHALL have parameter POLL_GAP, default 16, idle cycles between status reads (>=1).
REQ-007 SHALL have parameter MAX_POLLS, default 1024, status-read limit before sequence timeout.
REQ-008 Ports, in this order:
 clk  in  1  clock
 rst_n  in  1  asynchronous active-low reset
 start  in  1  one-cycle request to run a sequence
 tg_mask  in  NUM_TG  TGs to start and monitor; sampled on accepted start
 busy  out  1  sequence in progress
 done  out  1  one-cycle completion pulse
 tg_pass / tg_fail / tg_timeout  out  NUM_TG each  final per-TG status
 seq_timeout  out  1  MAX_POLLS reached without completion
 clock_count  out  64 x NUM_TG  captured clock counts
 avmm_address  out  ADDR_W  AVMM address
 avmm_read / avmm_write  out  1 each  AVMM commands
 avmm_writedata  out  64  write data
 avmm_byteenable  out  8  byte enables
 avmm_waitrequest  in  1  sink stall
 avmm_readdata  in  64  read data
 avmm_readdatavalid  in  1  read data strobe
 avmm_writeresponsevalid  in  1  write completion strobe

Function
REQ-009 SHALL always drive avmm_byteenable = 'hff; only one AVMM transaction outstanding at any time.
REQ-010 A command (read or write) SHALL stay asserted with address/data stable until a cycle with avmm_waitrequest=0; it SHALL deassert the following cycle.
REQ-011 FSM states: IDLE, WR_CTRL, WAIT_WRSP, RD_STAT, WAIT_STAT, GAP, RD_CLK, WAIT_CLK, DONE.
REQ-012 IDLE: start=1 with tg_mask!=0 -> latch mask, clear results, seq_timeout and poll counter, busy=1, next WR_CTRL; start=1 with tg_mask==0 -> DONE with no AVMM traffic and all results 0.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 WR_CTRL: write CTRL_ADDR, writedata = zero-extended mask; accepted -> WAIT_WRSP.
REQ-015 WAIT_WRSP: avmm_writeresponsevalid -> RD_STAT.
REQ-016 RD_STAT: read STAT_ADDR, increment poll counter on accept; -> WAIT_STAT.
REQ-017 TG_STAT layout per TG n: bit 4n active, 4n+1 pass, 4n+2 fail, 4n+3 timeout.
REQ-018 WAIT_STAT on readdatavalid: complete if every masked TG has active=0 and at least one of pass/fail/timeout=1; complete -> capture pass/fail/timeout for masked TGs (unmasked bits 0), go RD_CLK at lowest masked index.
REQ-019 Not complete and poll counter == MAX_POLLS -> seq_timeout=1, capture current status bits, DONE (no clock reads); otherwise -> GAP.
REQ-020 GAP SHALL wait exactly POLL_GAP cycles then enter RD_STAT.
REQ-021 RD_CLK/WAIT_CLK: read CLOCKS_ADDR+8n for each masked n in ascending order, storing readdata into clock_count[n]; unmasked entries SHALL be 0; after last -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, busy=0 in same cycle, next IDLE; results held until next accepted start.
REQ-023 readdatavalid/writeresponsevalid arriving in any state not awaiting them SHALL be ignored.
REQ-024 Poll counter SHALL be $clog2(MAX_POLLS+1) bits and SHALL not wrap.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE and drive busy, done, avmm_read, avmm_write, seq_timeout, all status and clock_count outputs, avmm_address and avmm_writedata to 0.
REQ-026 Reset mid-transaction SHALL abandon it; responses arriving after reset release SHALL be ignored.

Verification
REQ-027 start, mask='b0101, sink completes TG0/TG2 pass on 3rd status read, counts 'h100/'h200 -> one write 'h5 to 'h30, three reads 'h38, reads 'h40,'h50; done pulse; tg_pass='b0101, clock_count[0]='h100, [2]='h200.
REQ-028 waitrequest held high 5 cycles on CTRL write -> avmm_write high 6 cycles, address/data stable throughout, single write.
REQ-029 Sink never completes, MAX_POLLS=4 -> exactly 4 status reads spaced POLL_GAP+ cycles, seq_timeout=1, no clock reads, done pulse.
REQ-030 mask=0 start -> done 1 cycle after start, zero AVMM activity, all results 0.
REQ-031 start re-asserted while busy, and rst_n pulsed low during WAIT_STAT -> second start ignored; after reset all outputs 0, stale readdatavalid ignored, new start runs normally.
REQ-032 TG1 fail with TG0 pass, mask='b0011 -> tg_pass='b01, tg_fail='b10, both clock counts captured.
